data_mem_responder: RTL and testbench

- Responder (slave) end of the processor data-memory interface.
- Accepts MemRead/MemWrite strobes with dAddress/dWriteData from the multicycle core and returns dReadData plus a one-cycle ready pulse after a configurable number of wait states.
- Flags illegal accesses with err.
- Sits between top_proc's data port and the word-addressed storage array; it replaces the zero-latency data memory so the core FSM can be exercised against real wait states.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_word_array.sv | 23 ++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default base
// address and the bit positions of the latched error causes.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] DATA_BASE = 32'h10010000;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_BOTH     = 2;
    localparam int ERR_W        = 3;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, combinational read, no reset.
module mem_word_array #(
    parameter int DEPTH_WORDS = 128,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory port: accepts one request at a time,
// completes it after LATENCY cycles with a one-cycle ready pulse and an err flag.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 128,
    parameter logic [31:0] BASE_ADDR   = DATA_BASE,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [ERR_W-1:0] cause_q, cause_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [31:0]      offset;
    logic [AW-1:0]    idx_in;
    logic [ERR_W-1:0] cause_in;
    logic             req;
    logic             enter_resp;
    logic             live;
    logic             cmt_ok;
    logic             cmt_wr;
    logic [AW-1:0]    arr_addr;
    logic [31:0]      arr_wdata;
    logic [31:0]      arr_rdata;
    logic             arr_we;

    // Address decode; addresses below the base wrap to huge offsets and fail the range test.
    always_comb begin
        offset                 = dAddress - BASE_ADDR;
        idx_in                 = offset[AW+1:2];
        cause_in               = '0;
        cause_in[ERR_MISALIGN] = |dAddress[1:0];
        cause_in[ERR_RANGE]    = (offset >= SPAN);
        cause_in[ERR_BOTH]     = MemRead & MemWrite;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        cause_d    = cause_q;
        enter_resp = 1'b0;
        req        = MemRead | MemWrite;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = idx_in;
                    wdata_d = dWriteData;
                    wr_d    = MemWrite;
                    cause_d = cause_in;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is the accept edge, so the live inputs are used.
    always_comb begin
        live      = (state_q == IDLE);
        arr_addr  = live ? idx_in : idx_q;
        arr_wdata = live ? dWriteData : wdata_q;
        cmt_wr    = live ? MemWrite : wr_q;
        cmt_ok    = enter_resp & ((live ? cause_in : cause_q) == '0);
        arr_we    = cmt_ok & cmt_wr & rst;
        rdata_d   = (cmt_ok & ~cmt_wr) ? arr_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
        cause_q <= cause_d;
    end

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    assign dReadData = rdata_q;
    assign ready     = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign err       = ready & (|cause_q);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 1, 2 and 4
// driven from a vector table, plus a reset-abort sequence on the LATENCY=4 copy.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mr  [3];
    logic        mw  [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic [31:0] rdd [3];
    logic        rdy [3];
    logic        er  [3];
    logic        bsy [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS(128),
            .BASE_ADDR  (32'h10010000),
            .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .MemRead   (mr[g]),
            .MemWrite  (mw[g]),
            .dAddress  (ad[g]),
            .dWriteData(wd[g]),
            .dReadData (rdd[g]),
            .ready     (rdy[g]),
            .err       (er[g]),
            .busy      (bsy[g])
        );
    end

    typedef struct {
        int          sel;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int k;
        bit got;
        chk({tag, "_idle_busy"}, 32'(bsy[v.sel]), 32'd0);
        mr[v.sel] = v.rd;
        mw[v.sel] = v.wr;
        ad[v.sel] = v.addr;
        wd[v.sel] = v.wdata;
        @(negedge clk);
        mr[v.sel] = 1'b0;
        mw[v.sel] = 1'b0;
        k   = 1;
        got = 1'b0;
        while (k <= 20) begin
            if (rdy[v.sel]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, got ? 32'(k) : 32'd99, 32'(lat_of(v.sel)));
        chk({tag, "_err"}, 32'(er[v.sel]), 32'(v.exp_err));
        chk({tag, "_rdata"}, rdd[v.sel], v.exp_rd);
        chk({tag, "_busy_resp"}, 32'(bsy[v.sel]), 32'd1);
        @(negedge clk);
        chk({tag, "_ready_drop"}, 32'(rdy[v.sel]), 32'd0);
        chk({tag, "_busy_drop"}, 32'(bsy[v.sel]), 32'd0);
    endtask

    vec_t vecs[15];

    initial begin
        bit seen;

        vecs[0]  = '{1, 1'b0, 1'b1, 32'h10010008, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1, 1'b1, 1'b0, 32'h10010008, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1, 1'b0, 1'b1, 32'h100101FC, 32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1, 1'b0, 1'b1, 32'h10010000, 32'h00000055, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1, 1'b1, 1'b0, 32'h100101FC, 32'h00000000, 32'h12345678, 1'b0};
        vecs[5]  = '{1, 1'b1, 1'b0, 32'h10010006, 32'h00000000, 32'h12345678, 1'b1};
        vecs[6]  = '{1, 1'b0, 1'b1, 32'h10010200, 32'h0000AAAA, 32'h12345678, 1'b1};
        vecs[7]  = '{1, 1'b0, 1'b1, 32'h1000FFFC, 32'h0000BBBB, 32'h12345678, 1'b1};
        vecs[8]  = '{1, 1'b1, 1'b1, 32'h10010000, 32'h00000066, 32'h12345678, 1'b1};
        vecs[9]  = '{1, 1'b1, 1'b0, 32'h100101FC, 32'h00000000, 32'h12345678, 1'b0};
        vecs[10] = '{1, 1'b1, 1'b0, 32'h10010000, 32'h00000000, 32'h00000055, 1'b0};
        vecs[11] = '{0, 1'b0, 1'b1, 32'h10010000, 32'h00000011, 32'h00000000, 1'b0};
        vecs[12] = '{0, 1'b1, 1'b0, 32'h10010000, 32'h00000000, 32'h00000011, 1'b0};
        vecs[13] = '{2, 1'b0, 1'b1, 32'h10010010, 32'h77777777, 32'h00000000, 1'b0};
        vecs[14] = '{2, 1'b1, 1'b0, 32'h10010010, 32'h00000000, 32'h77777777, 1'b0};

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mr[i] = 1'b0;
            mw[i] = 1'b0;
            ad[i] = '0;
            wd[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_rdata", i), rdd[i], 32'd0);
            chk($sformatf("rst%0d_ready", i), 32'(rdy[i]), 32'd0);
            chk($sformatf("rst%0d_err", i), 32'(er[i]), 32'd0);
            chk($sformatf("rst%0d_busy", i), 32'(bsy[i]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Reset lands mid-WAIT on the LATENCY=4 write of 0xCAFEF00D.
        seen  = 1'b0;
        mw[2] = 1'b1;
        ad[2] = 32'h10010010;
        wd[2] = 32'hCAFEF00D;
        @(negedge clk);
        mw[2] = 1'b0;
        if (rdy[2]) seen = 1'b1;
        @(negedge clk);
        if (rdy[2]) seen = 1'b1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rdy[2]) seen = 1'b1;
        end
        chk("abort_busy_in_rst", 32'(bsy[2]), 32'd0);
        chk("abort_rdata_in_rst", rdd[2], 32'd0);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rdy[2]) seen = 1'b1;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        run_txn(vecs[14], "v14");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
